// File: rtl/seq_110011_tx_pkg.sv
// Shared types and constants for the 110011-sync serial frame transmitter.
package seq_110011_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [5:0] SYNC_WORD_DEF = 6'b110011;
    localparam logic [4:0] STUFF_TRIGGER = 5'b11001;
    localparam int         SYNC_LEN      = 6;
    localparam int         HIST_W        = 5;
    localparam int         DATA_W_DEF    = 8;
    localparam int         GAP_LEN_DEF   = 2;

endpackage

// File: rtl/seq_110011_tx.sv
// Serial frame transmitter: sync word, bit-stuffed payload, then an idle gap.
// Stuffing keeps the payload from ever recreating the sync word on the line.
module seq_110011_tx
    import seq_110011_tx_pkg::*;
#(
    parameter logic [5:0] SYNC_WORD = SYNC_WORD_DEF,
    parameter int         DATA_W    = DATA_W_DEF,
    parameter int         GAP_LEN   = GAP_LEN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              busy,
    output logic              x,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    state_t              state_q, state_d;
    logic                x_q, x_d;
    logic                done_q, done_d;
    logic [HIST_W-1:0]   hist_q, hist_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]          sync_idx_q, sync_idx_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

    logic pay_bit;
    logic stuff;
    logic emit_payload;

    assign pay_bit      = shreg_q[DATA_W-1];
    assign stuff        = (hist_q == STUFF_TRIGGER) && pay_bit;
    // The edge ending the last sync bit already emits the first payload bit.
    assign emit_payload = ((state_q == SYNC) && (sync_idx_q == 3'(SYNC_LEN))) ||
                          ((state_q == DATA) && (bit_cnt_q != '0));

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        x_d        = 1'b0;
        done_d     = 1'b0;
        hist_d     = hist_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        sync_idx_d = sync_idx_q;
        gap_cnt_d  = gap_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d    = data;
                    x_d        = SYNC_WORD[SYNC_LEN-1];
                    hist_d     = {{(HIST_W-1){1'b0}}, SYNC_WORD[SYNC_LEN-1]};
                    sync_idx_d = 3'd1;
                    bit_cnt_d  = CNT_W'(DATA_W);
                    state_d    = SYNC;
                end
            end
            SYNC: begin
                if (sync_idx_q != 3'(SYNC_LEN)) begin
                    x_d        = SYNC_WORD[3'(SYNC_LEN-1) - sync_idx_q];
                    hist_d     = {hist_q[HIST_W-2:0], x_d};
                    sync_idx_d = sync_idx_q + 3'd1;
                end else begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_cnt_q == '0) begin
                    state_d   = GAP;
                    done_d    = 1'b1;
                    gap_cnt_d = GAP_W'(GAP_LEN - 1);
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) state_d = IDLE;
                else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // A stuffed 0 goes out in place of a 1 that would complete the trigger.
        if (emit_payload) begin
            if (stuff) begin
                x_d = 1'b0;
            end else begin
                x_d       = pay_bit;
                shreg_d   = shreg_q << 1;
                bit_cnt_d = bit_cnt_q - CNT_W'(1);
            end
            hist_d = {hist_q[HIST_W-2:0], x_d};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state_q    <= IDLE;
            x_q        <= 1'b0;
            done_q     <= 1'b0;
            hist_q     <= '0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            sync_idx_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            done_q     <= done_d;
            hist_q     <= hist_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            sync_idx_q <= sync_idx_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q != IDLE);
    assign x     = x_q;
    assign done  = done_q;

endmodule

// File: tb/tb_seq_110011_tx.sv
// Bench for seq_110011_tx: a frame-level model predicts every output cycle,
// plus directed frames with hand-computed latencies and bit patterns.
module tb_seq_110011_tx;

    localparam int DATA_W  = 8;
    localparam int GAP_LEN = 2;

    typedef bit bitq_t[$];
    typedef struct packed {
        logic ready;
        logic busy;
        logic x;
        logic done;
    } obs_t;

    localparam obs_t IDLE_OBS = 4'b1000;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [DATA_W-1:0] data  = '0;
    logic              ready, busy, x, done;

    int tests = 0;
    int fails = 0;

    obs_t exp_q[$];
    obs_t exp_cur = IDLE_OBS;
    bit   chk_en  = 1'b0;

    always #5 clk = ~clk;

    seq_110011_tx #(.DATA_W(DATA_W), .GAP_LEN(GAP_LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .data  (data),
        .ready (ready),
        .busy  (busy),
        .x     (x),
        .done  (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Whole emitted frame from the line rules: sync word, then payload with a 0
    // inserted whenever the last five line bits are 11001 and the next bit is 1.
    function automatic bitq_t frame_bits(input logic [DATA_W-1:0] d);
        bitq_t     b;
        bit [5:0]  sw   = 6'b110011;
        bit [4:0]  trig = 5'b11001;
        bit [4:0]  w;
        for (int i = 5; i >= 0; i--) b.push_back(sw[i]);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            w = '0;
            for (int k = 0; k < 5; k++)
                if (b.size() > k) w[k] = b[b.size() - 1 - k];
            if (w == trig && d[i]) b.push_back(1'b0);
            b.push_back(d[i]);
        end
        return b;
    endfunction

    function automatic logic [31:0] pack_bits(input bitq_t q);
        logic [31:0] v = '0;
        foreach (q[i]) v = {v[30:0], q[i]};
        return v;
    endfunction

    // Model: per-cycle expected outputs for the cycle following each edge.
    always @(posedge clk) begin
        bitq_t bq;
        if (!reset) begin
            exp_q.delete();
            exp_cur = IDLE_OBS;
        end else begin
            if (exp_cur.ready && start) begin
                bq = frame_bits(data);
                foreach (bq[i]) exp_q.push_back(obs_t'({1'b0, 1'b1, bq[i], 1'b0}));
                exp_q.push_back(obs_t'(4'b0101));
                for (int g = 1; g < GAP_LEN; g++) exp_q.push_back(obs_t'(4'b0100));
            end
            exp_cur = (exp_q.size() != 0) ? exp_q.pop_front() : IDLE_OBS;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", ready, exp_cur.ready);
            check("busy",  busy,  exp_cur.busy);
            check("x",     x,     exp_cur.x);
            check("done",  done,  exp_cur.done);
        end
    end

    // Sends one frame from idle and measures done/ready cycles and sync-word hits.
    task automatic run_frame(input logic [DATA_W-1:0] d, input int exp_done_c,
                             input int exp_ready_c, input bit inject, input string tag);
        int       c       = 0;
        int       done_c  = 0;
        int       ready_c = 0;
        int       hits    = 0;
        logic [5:0] sh    = '0;
        data  = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (c < 40) begin
            c++;
            if (ready) begin
                ready_c = c;
                break;
            end
            sh = {sh[4:0], x};
            if (sh == 6'b110011) hits++;
            if (done && done_c == 0) done_c = c;
            if (inject) begin
                start = (c == 8);
                if (c == 8) data = 8'hFF;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_done_cycle"},  done_c,  exp_done_c);
        check({tag, "_ready_cycle"}, ready_c, exp_ready_c);
        check({tag, "_sync_hits"},   hits,    1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        check("model_A5", pack_bits(frame_bits(8'hA5)), 32'b11001110100101);
        check("model_33", pack_bits(frame_bits(8'h33)), 32'b110011001010011);
        check("model_CC", pack_bits(frame_bits(8'hCC)), 32'b110011110010100);
        check("model_CC_len", frame_bits(8'hCC).size(), 15);

        // Reset held with start high: must be ignored.
        start = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;

        repeat (5) begin
            @(negedge clk);
            check("idle_ready", ready, 1'b1);
            check("idle_busy",  busy,  1'b0);
            check("idle_x",     x,     1'b0);
            check("idle_done",  done,  1'b0);
        end

        run_frame(8'hA5, 15, 17, 1'b0, "A5");
        run_frame(8'h33, 16, 18, 1'b0, "33");
        run_frame(8'hCC, 16, 18, 1'b0, "CC");
        run_frame(8'hA5, 15, 17, 1'b1, "A5_inject");

        // Abort during the third sync bit.
        data  = 8'h5A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("sync3_x", x, 1'b0);
        check("sync3_busy", busy, 1'b1);
        reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check("abort_ready", ready, 1'b1);
        check("abort_busy",  busy,  1'b0);
        check("abort_x",     x,     1'b0);
        reset = 1'b1;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", done, 1'b0);
            check("abort_idle", ready, 1'b1);
        end
        run_frame(8'h5A, 15, 17, 1'b0, "5A_after_abort");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_110011_tx.md
SEQ_110011_TX -- requirements
Module: seq_110011_tx

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 6'b110011, the sync pattern sent MSB first.
REQ-002 SHALL have parameter DATA_W, default 8, the payload width in bits.
REQ-003 SHALL have parameter GAP_LEN, default 2, the number of idle-0 cycles after each frame.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset is synchronous and active-low.
REQ-006 start  input  1  frame request; accepted only when ready=1.
REQ-007 data  input  DATA_W  payload, sampled on the accept edge.
REQ-008 ready  output  1  high only in IDLE.
REQ-009 busy  output  1  high in SYNC, DATA and GAP.
REQ-010 x  output  1  registered serial bit stream; 0 when idle.
REQ-011 done  output  1  one-cycle pulse marking the end of the payload.

Function
REQ-012 SHALL implement an FSM with four states: IDLE, SYNC, DATA, GAP.
REQ-013 IDLE: on the rising edge where start=1 and ready=1, SHALL latch data into a shift register, clear the 5-bit history to 0, and go to SYNC.
REQ-014 Latency: x SHALL carry the first SYNC_WORD bit in the cycle immediately after the accept edge.
REQ-015 SYNC: SHALL emit the 6 SYNC_WORD bits MSB first, one per cycle, then go to DATA.
REQ-016 DATA: SHALL emit payload bits MSB first, one per cycle.
REQ-017 Bit stuffing: if the history of the last 5 emitted bits equals 5'b11001 and the next payload bit is 1, SHALL emit a stuffed 0 instead, without consuming the payload bit.
REQ-018 History SHALL shift in every emitted bit, including sync bits and stuffed bits; the payload therefore never forms SYNC_WORD, including across the sync/payload boundary.
REQ-019 After the last payload bit is emitted, SHALL go to GAP and assert done=1 for exactly the first GAP cycle.
REQ-020 GAP: SHALL hold x=0 for GAP_LEN cycles, then return to IDLE with ready=1.
REQ-021 start while busy SHALL be ignored; data SHALL not be resampled mid-frame.
REQ-022 Frame length SHALL be 6+DATA_W+stuffs cycles; worst-case stuff count is bounded by the payload width.
REQ-023 All outputs SHALL be registered; no combinational path from start or data to x.

Reset
REQ-024 When reset=0 at a rising edge: state=IDLE, x=0, ready=1, busy=0, done=0, history=0, counters=0.
REQ-025 Reset mid-frame SHALL abort the frame: the next cycle is idle, with no done pulse and no further frame bits.
REQ-026 start asserted in the same cycle as reset=0 SHALL be ignored.

Structure
REQ-027 A shared package SHALL hold the state enumeration (IDLE/SYNC/DATA/GAP), the SYNC_WORD constant, the STUFF_TRIGGER constant 5'b11001, and the default widths.
REQ-028 The block SHALL be a single module with no sub-modules; the bit counter width SHALL be sized by $clog2(DATA_W+1).

Verification
REQ-029 Reset release, start=0 for 5 cycles -> ready=1, busy=0, x=0, done=0 throughout.
REQ-030 start with data=8'hA5 -> x = 110011 then 10100101, 14 cycles, no stuffing; done=1 on the 15th cycle; then 2 cycles of x=0; ready=1 on the 17th cycle.
REQ-031 start with data=8'h33 -> x = 110011 then 001010011 (stuffed 0 after the third payload bit), 15 cycles; done on the 16th cycle.
REQ-032 start with data=8'hCC -> payload bits 110010100 (stuff after the fifth bit), 9 cycles; feeding x into a 110011 detector flags only the sync.
REQ-033 start pulsed during DATA with different data -> ignored; the frame completes with the original payload.
REQ-034 reset=0 during the 3rd SYNC bit -> next cycle x=0, ready=1, busy=0; no done pulse; a new start then sends a full frame.
